// File: rtl/lda_pkg.sv
// Shared types and constants for the line-drawing command scheduler.
// Coordinate widths follow the 320x240 frame buffer.
package lda_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        RUN     = 3'd2,
        RELEASE = 3'd3,
        REPORT  = 3'd4
    } state_e;

    localparam int X_W = 9;
    localparam int Y_W = 8;

    localparam logic [1:0] ST_OK    = 2'b00;
    localparam logic [1:0] ST_TMO   = 2'b01;
    localparam logic [1:0] ST_RANGE = 2'b10;

    localparam int X_MAX_DEF = 319;
    localparam int Y_MAX_DEF = 239;

    // True when any endpoint lies outside the visible frame.
    function automatic logic coord_bad(
        input logic [X_W-1:0] x0,
        input logic [Y_W-1:0] y0,
        input logic [X_W-1:0] x1,
        input logic [Y_W-1:0] y1,
        input logic [X_W-1:0] xmax,
        input logic [Y_W-1:0] ymax
    );
        return (x0 > xmax) || (x1 > xmax) || (y0 > ymax) || (y1 > ymax);
    endfunction

endpackage

// File: rtl/lda_sched_rr_arb2.sv
// Two-way round-robin arbiter: on a tie the requester that did not win last
// time is granted; a lone requester always wins.
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    input  logic       enable,
    output logic [1:0] grant
);

    // One-hot grant selection, suppressed while the scheduler is occupied.
    always_comb begin
        grant = 2'b00;
        if (!enable) begin
            grant = 2'b00;
        end else if (valid == 2'b11) begin
            grant = last_grant ? 2'b01 : 2'b10;
        end else begin
            grant = valid;
        end
    end

endmodule

// File: rtl/lda_sched.sv
// Round-robin command scheduler for the single Bresenham line engine: grants
// a requester, drives the level start/done handshake and reports completion.
module lda_sched
    import lda_pkg::*;
#(
    parameter int GAP     = 2,
    parameter int TIMEOUT = 4095,
    parameter int X_MAX   = X_MAX_DEF,
    parameter int Y_MAX   = Y_MAX_DEF
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           req0_valid,
    input  logic [X_W-1:0] req0_x0,
    input  logic [Y_W-1:0] req0_y0,
    input  logic [X_W-1:0] req0_x1,
    input  logic [Y_W-1:0] req0_y1,
    input  logic           req0_colour,
    output logic           req0_ready,
    output logic           req0_done,
    input  logic           req1_valid,
    input  logic [X_W-1:0] req1_x0,
    input  logic [Y_W-1:0] req1_y0,
    input  logic [X_W-1:0] req1_x1,
    input  logic [Y_W-1:0] req1_y1,
    input  logic           req1_colour,
    output logic           req1_ready,
    output logic           req1_done,
    output logic [1:0]     status,
    output logic           busy,
    output logic [X_W-1:0] lda_x0,
    output logic [Y_W-1:0] lda_y0,
    output logic [X_W-1:0] lda_x1,
    output logic [Y_W-1:0] lda_y1,
    output logic           lda_colour,
    output logic           lda_start,
    input  logic           lda_done
);

    localparam int             GW    = $clog2(GAP + 1);
    localparam logic [GW-1:0]  GAP_L = GW'(GAP);
    localparam logic [11:0]    TMO_L = 12'(TIMEOUT);
    localparam logic [X_W-1:0] X_LIM = X_W'(X_MAX);
    localparam logic [Y_W-1:0] Y_LIM = Y_W'(Y_MAX);

    state_e        state_r;
    logic          owner_r;
    logic          last_grant_r;
    logic [1:0]    st_hold_r;
    logic [11:0]   run_cnt_r;
    logic [GW-1:0] gap_cnt_r;
    logic [1:0]    grant_s;
    logic          range_err_s;

    rr_arb2 u_arb (
        .valid      ({req1_valid, req0_valid}),
        .last_grant (last_grant_r),
        .enable     (state_r == IDLE),
        .grant      (grant_s)
    );

    // The engine-facing registers double as the command latch.
    assign range_err_s = coord_bad(lda_x0, lda_y0, lda_x1, lda_y1, X_LIM, Y_LIM);

    // Scheduler FSM; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            owner_r      <= 1'b0;
            last_grant_r <= 1'b1;
            st_hold_r    <= ST_OK;
            run_cnt_r    <= 12'd0;
            gap_cnt_r    <= '0;
            req0_ready   <= 1'b0;
            req1_ready   <= 1'b0;
            req0_done    <= 1'b0;
            req1_done    <= 1'b0;
            status       <= ST_OK;
            busy         <= 1'b0;
            lda_x0       <= '0;
            lda_y0       <= '0;
            lda_x1       <= '0;
            lda_y1       <= '0;
            lda_colour   <= 1'b0;
            lda_start    <= 1'b0;
        end else begin
            req0_ready <= 1'b0;
            req1_ready <= 1'b0;
            req0_done  <= 1'b0;
            req1_done  <= 1'b0;
            case (state_r)
                IDLE: begin
                    status <= ST_OK;
                    if (grant_s != 2'b00) begin
                        req0_ready   <= grant_s[0];
                        req1_ready   <= grant_s[1];
                        owner_r      <= grant_s[1];
                        last_grant_r <= grant_s[1];
                        lda_x0       <= grant_s[1] ? req1_x0 : req0_x0;
                        lda_y0       <= grant_s[1] ? req1_y0 : req0_y0;
                        lda_x1       <= grant_s[1] ? req1_x1 : req0_x1;
                        lda_y1       <= grant_s[1] ? req1_y1 : req0_y1;
                        lda_colour   <= grant_s[1] ? req1_colour : req0_colour;
                        busy         <= 1'b1;
                        state_r      <= LOAD;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                LOAD: begin
                    if (range_err_s) begin
                        st_hold_r <= ST_RANGE;
                        state_r   <= REPORT;
                    end else begin
                        lda_start <= 1'b1;
                        run_cnt_r <= 12'd1;
                        state_r   <= RUN;
                    end
                end
                // run_cnt_r==1 marks the first RUN cycle, where done may be stale.
                RUN: begin
                    if ((run_cnt_r != 12'd1) && lda_done) begin
                        lda_start <= 1'b0;
                        st_hold_r <= ST_OK;
                        gap_cnt_r <= GW'(1);
                        state_r   <= RELEASE;
                    end else if (run_cnt_r == TMO_L) begin
                        lda_start <= 1'b0;
                        st_hold_r <= ST_TMO;
                        gap_cnt_r <= GW'(1);
                        state_r   <= RELEASE;
                    end else begin
                        run_cnt_r <= run_cnt_r + 12'd1;
                    end
                end
                RELEASE: begin
                    if (gap_cnt_r == GAP_L) begin
                        state_r <= REPORT;
                    end else begin
                        gap_cnt_r <= gap_cnt_r + GW'(1);
                    end
                end
                REPORT: begin
                    req0_done <= ~owner_r;
                    req1_done <= owner_r;
                    status    <= st_hold_r;
                    state_r   <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lda_sched.sv
// Randomised scoreboard bench for lda_sched with a behavioural engine model
// whose done level rises a chosen number of cycles after start is seen.
module tb_lda_sched;

    localparam int GAP_TB = 2;
    localparam int TMO_TB = 48;

    typedef struct {
        int         req;
        logic [8:0] x0;
        logic [7:0] y0;
        logic [8:0] x1;
        logic [7:0] y1;
        logic       col;
        logic [1:0] st;
        int         run_len;
        int         lat;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       vld[2];
    logic [8:0] ax0[2];
    logic [7:0] ay0[2];
    logic [8:0] ax1[2];
    logic [7:0] ay1[2];
    logic       acol[2];

    logic       req0_ready, req0_done, req1_ready, req1_done;
    logic [1:0] status;
    logic       busy;
    logic [8:0] lda_x0, lda_x1;
    logic [7:0] lda_y0, lda_y1;
    logic       lda_colour, lda_start;
    logic       lda_done;

    int   compared = 0;
    int   mismatched = 0;
    exp_t sbq[$];
    int   eng_delay = 1;
    int   eng_cnt = 0;
    int   cyc = 0;
    int   rdy_cyc = 0;
    int   start_cnt = 0;
    bit   inflight = 1'b0;
    bit   last_m = 1'b1;
    bit   prev_done = 1'b0;

    lda_sched #(.GAP(GAP_TB), .TIMEOUT(TMO_TB), .X_MAX(319), .Y_MAX(239)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(vld[0]), .req0_x0(ax0[0]), .req0_y0(ay0[0]), .req0_x1(ax1[0]),
        .req0_y1(ay1[0]), .req0_colour(acol[0]), .req0_ready(req0_ready), .req0_done(req0_done),
        .req1_valid(vld[1]), .req1_x0(ax0[1]), .req1_y0(ay0[1]), .req1_x1(ax1[1]),
        .req1_y1(ay1[1]), .req1_colour(acol[1]), .req1_ready(req1_ready), .req1_done(req1_done),
        .status(status), .busy(busy),
        .lda_x0(lda_x0), .lda_y0(lda_y0), .lda_x1(lda_x1), .lda_y1(lda_y1),
        .lda_colour(lda_colour), .lda_start(lda_start), .lda_done(lda_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Engine: parked with done high; done rises after eng_delay cycles of start.
    always @(posedge clk) begin
        if (!lda_start) begin
            eng_cnt  <= 0;
            lda_done <= 1'b1;
        end else begin
            eng_cnt  <= eng_cnt + 1;
            lda_done <= (eng_cnt + 1 >= eng_delay);
        end
    end

    // Monitor: grant prediction, coordinate/length/latency/status checks.
    always @(posedge clk) begin
        logic [1:0] v_s, rdy, dn;
        logic       r_s;
        int         exp_g;
        exp_t       e;
        v_s = {vld[1], vld[0]};
        r_s = reset;
        #1;
        cyc++;
        rdy = {req1_ready, req0_ready};
        dn  = {req1_done, req0_done};
        if (r_s) begin
            check("reset_ctl", {req0_ready, req1_ready, req0_done, req1_done, status, busy, lda_start}, 64'd0);
            check("reset_coord", {lda_x0, lda_y0, lda_x1, lda_y1, lda_colour}, 64'd0);
            sbq.delete();
            inflight  = 1'b0;
            last_m    = 1'b1;
            prev_done = 1'b0;
            start_cnt = 0;
        end else begin
            if (rdy != 2'b00) begin
                exp_g = (v_s == 2'b11) ? (last_m ? 0 : 1) : (v_s[1] ? 1 : 0);
                check("ready_had_valid", 64'(v_s != 2'b00), 64'd1);
                check("grant", 64'(rdy), (exp_g == 1) ? 64'd2 : 64'd1);
                check("ready_while_busy", 64'(inflight), 64'd0);
                last_m    = rdy[1];
                inflight  = 1'b1;
                rdy_cyc   = cyc;
                start_cnt = 0;
            end
            if (lda_start) begin
                if (start_cnt == 0 && sbq.size() > 0)
                    check("coords", {lda_x0, lda_y0, lda_x1, lda_y1, lda_colour},
                          {sbq[0].x0, sbq[0].y0, sbq[0].x1, sbq[0].y1, sbq[0].col});
                start_cnt++;
            end
            if (dn != 2'b00) begin
                if (sbq.size() == 0) begin
                    check("done_unexpected", 64'(dn), 64'd0);
                end else begin
                    e = sbq.pop_front();
                    check("done_owner", 64'(dn), (e.req == 1) ? 64'd2 : 64'd1);
                    check("status", 64'(status), 64'(e.st));
                    check("latency", 64'(cyc - rdy_cyc), 64'(e.lat));
                    check("start_len", 64'(start_cnt), 64'(e.run_len));
                    check("busy_at_done", 64'(busy), 64'd1);
                end
                inflight = 1'b0;
            end else if (prev_done && rdy == 2'b00) begin
                check("busy_after_done", 64'(busy), 64'd0);
            end
            prev_done = (dn != 2'b00);
        end
    end

    task automatic issue(input int r, input int x0, input int y0, input int x1, input int y1,
                         input bit c, input int d);
        exp_t e;
        bit   got;
        @(negedge clk);
        ax0[r] = 9'(x0); ay0[r] = 8'(y0); ax1[r] = 9'(x1); ay1[r] = 8'(y1); acol[r] = c;
        vld[r] = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(negedge clk);
            if ((r == 0) ? req0_ready : req1_ready) got = 1'b1;
        end
        vld[r] = 1'b0;
        if (!got) begin
            check("ready_wait", 64'd0, 64'd1);
        end else begin
            eng_delay = d;
            e.req = r; e.x0 = 9'(x0); e.y0 = 8'(y0); e.x1 = 9'(x1); e.y1 = 8'(y1); e.col = c;
            if (x0 > 319 || x1 > 319 || y0 > 239 || y1 > 239) begin
                e.st = 2'b10; e.run_len = 0; e.lat = 2;
            end else begin
                // Done is first visible in RUN cycle d+1; it must arrive by TMO_TB.
                e.run_len = (d + 1 <= TMO_TB) ? d + 1 : TMO_TB;
                e.st      = (d + 1 <= TMO_TB) ? 2'b00 : 2'b01;
                e.lat     = 1 + e.run_len + GAP_TB + 1;
            end
            sbq.push_back(e);
        end
    endtask

    task automatic rnd_issue(input int r);
        int x0, y0, x1, y1;
        x0 = $urandom_range(0, 319); y0 = $urandom_range(0, 239);
        x1 = $urandom_range(0, 319); y1 = $urandom_range(0, 239);
        if ($urandom_range(0, 7) == 0) begin
            case ($urandom_range(0, 3))
                0:       x0 = $urandom_range(320, 511);
                1:       x1 = $urandom_range(320, 511);
                2:       y0 = $urandom_range(240, 255);
                default: y1 = $urandom_range(240, 255);
            endcase
        end
        issue(r, x0, y0, x1, y1, 1'($urandom_range(0, 1)), $urandom_range(1, 60));
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk);
            if (sbq.size() == 0 && !inflight && !busy) ok = 1'b1;
        end
        if (!ok) check("idle_wait", 64'd0, 64'd1);
    endtask

    initial begin
        bit seen;
        for (int i = 0; i < 2; i++) begin
            vld[i] = 1'b0; ax0[i] = '0; ay0[i] = '0; ax1[i] = '0; ay1[i] = '0; acol[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;

        issue(0, 10, 20, 100, 50, 1'b1, 40);
        wait_idle();
        for (int k = 0; k < 2; k++) begin
            fork
                issue(0, 1, 2, 3, 4, 1'b0, 5);
                issue(1, 300, 200, 0, 0, 1'b1, 6);
            join
            wait_idle();
        end
        issue(1, 0, 0, 320, 10, 1'b1, 5);
        wait_idle();
        issue(0, 50, 60, 70, 80, 1'b0, 200);
        issue(0, 5, 6, 7, 8, 1'b1, 7);
        wait_idle();
        issue(1, 319, 239, 0, 0, 1'b1, TMO_TB - 1);
        issue(0, 0, 0, 0, 240, 1'b0, 3);
        issue(1, 9, 9, 9, 9, 1'b0, TMO_TB);
        issue(0, 12, 34, 12, 34, 1'b1, 1);
        wait_idle();

        for (int k = 0; k < 24; k++) begin
            case ($urandom_range(0, 2))
                0: rnd_issue(0);
                1: rnd_issue(1);
                default: begin
                    fork
                        rnd_issue(0);
                        rnd_issue(1);
                    join
                end
            endcase
            wait_idle();
        end

        issue(0, 30, 40, 200, 100, 1'b1, 30);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (lda_start) seen = 1'b1;
        end
        check("start_before_reset", 64'(seen), 64'd1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (60) @(negedge clk);
        fork
            issue(0, 100, 100, 110, 120, 1'b0, 4);
            issue(1, 101, 100, 110, 120, 1'b1, 4);
        join
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
